oup_ulpi_tx_arbiter: RTL and testbench
======================================

Name: oup_ulpi_tx_arbiter

Overview:
Sequencer and arbiter in front of the ULPI sync-mode TX state machine (oup_sm_ulpi_syncmode_tx). Shares it between two requesters: the packet engine (USB TX) and the PHY register access port (REGW/REGR, immediate and extended). Encodes the 8-bit instruction, issues exec, tracks completion, retries on exec_aborted, and reports done or error per request.

Parameters:
MAX_RETRY, 3, re-issues allowed after an aborted execution before reporting an error (0 = no retry).
START_TIMEOUT, 64, ulpi_clk_i cycles ISSUE may wait for exec_ready_i to fall before reporting an error.

Ports:
ulpi_clk_i  in  1  ULPI 60 MHz clock; this block uses the posedge.
rst_ni  in  1  asynchronous, active-low reset.
pkt_req_i  in  1  packet transmit request; held until pkt_gnt_o.
pkt_pid_i  in  4  USB PID for the TX CMD.
pkt_gnt_o  out  1  1-cycle pulse: request accepted, PID latched.
pkt_done_o  out  1  1-cycle pulse: transmit completed without abort.
pkt_err_o  out  1  1-cycle pulse: retries exhausted or start timeout.
reg_req_i  in  1  register access request; held until reg_gnt_o.
reg_we_i  in  1  1 = write, 0 = read.
reg_addr_i  in  8  PHY register address.
reg_wdata_i  in  8  write data.
reg_gnt_o / reg_done_o / reg_err_o  out  1 each  same semantics as the pkt_* outputs.
instruction_o  out  8  to TX machine instruction_i; stable from ISSUE until done/err.
exec_o  out  1  to TX machine exec_i.
exec_ready_i  in  1  from TX machine exec_ready_o.
exec_aborted_i  in  1  from TX machine exec_aborted_o.
phyreg_o  out  8  to TX machine phyreg_i (latched write data).
phyreg_addr_o  out  8  to TX machine phyreg_addr_i (latched full address).
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state IDLE; every output 0; latches and counters cleared. Reset mid-operation drops exec_o immediately. The TX machine's own reset handles that side.
- States: IDLE, ISSUE, WAIT_DONE, DONE, ERR.
- IDLE:
  - If any request is pending, arbitrate (fixed priority reg > pkt by default). Pulse the winner's gnt_o and latch operands. Go to ISSUE next cycle.
  - Grant requires at least one request. Latency from req to gnt is 1 cycle.
- Encoding:
  - pkt: instruction_o = {2'b01, 2'b00, pid}.
  - reg: opcode = we ? 2'b10 : 2'b11.
  - If addr <= 8'h3F and addr != 8'h2F: data = addr[5:0].
  - Otherwise (extended): data = 6'h2F and phyreg_addr_o = addr.
  - phyreg_addr_o always carries the latched addr. phyreg_o = wdata.
- ISSUE:
  - exec_o = 1, held until exec_ready_i is sampled 0. Then exec_o = 0 and go to WAIT_DONE.
  - A start counter increments each cycle. Reaching START_TIMEOUT goes to ERR. This covers ulpi_dir held high keeping the TX machine out of IDLE.
- WAIT_DONE: wait for exec_ready_i = 1.
  - exec_aborted_i = 0: go to DONE.
  - exec_aborted_i = 1 and retry_cnt < MAX_RETRY: increment retry_cnt, clear the start counter, go to ISSUE. The instruction is unchanged.
  - exec_aborted_i = 1 and retry_cnt = MAX_RETRY: go to ERR.
  - WAIT_DONE has no timeout. The TX machine guarantees return to IDLE/ABORT.
- DONE / ERR: pulse the owner's done_o / err_o for 1 cycle. Clear the counters. Return to IDLE; the next grant is possible in the following cycle.
- Requests arriving while busy stay pending; requesters must hold req. A requester dropping req before gnt is legal and gets no response.
- Both requests in the same cycle: exactly one gnt.
- Counters: retry_cnt is $clog2(MAX_RETRY+1) wide and saturates. The start counter is $clog2(START_TIMEOUT+1) wide.

Optional Feature:
OUP_ULPI_TX_ARB_RR_EN:
- Defined: round-robin arbitration. A last-grant bit flips after each DONE/ERR, and the simultaneous-request winner is the requester not served last. Reset value favours reg.
- Undefined: fixed priority, reg over pkt, and the last-grant bit is absent.

Decomposition:
- Package oup_ulpi_tx_arbiter_p holds:
  - arb_state_t enum.
  - requester_t enum (REQ_REG, REQ_PKT).
  - constant ULPI_EXTREG_IMM = 6'h2F.
  - function encode_instruction(requester, we, addr, pid), returning oup_sm_ulpi_syncmode_tx_p::instruction_union_t.
- One sub-module: oup_ulpi_tx_arb2, a 2-way arbiter with fixed-priority or round-robin selection under the macro.

Test Plan:
- Reg write: addr 8'h16, wdata 8'hA5, ideal TX model. Expect reg_gnt 1 cycle after req, instruction_o = 8'h96, phyreg_o = 8'hA5, exactly one reg_done pulse, exec_o low after exec_ready falls.
- Extended read: addr 8'h85. Expect instruction_o = 8'hEF, phyreg_addr_o = 8'h85. Model completes without abort: reg_done pulses and reg_err stays 0.
- Packet, PID 4'h1; model aborts twice then succeeds. Expect instruction_o = 8'h41, 3 exec issues, pkt_done pulses. With 4 aborts at MAX_RETRY = 3: 4 issues, then pkt_err pulses.
- exec_ready held high for 64 cycles after ISSUE. Expect reg_err pulse after 64 cycles, exec_o = 0, busy_o = 0.
- pkt_req and reg_req asserted together 3 times. Without the macro, reg is granted until served and then pkt. With OUP_ULPI_TX_ARB_RR_EN: reg, pkt, reg.
- rst_ni low in WAIT_DONE. Expect all outputs 0 immediately. After release, a pending request is granted within 1 cycle.

Source files
------------

// File: rtl/oup_ulpi_tx_arbiter_pkg.sv
// Shared types and the instruction encoder for the ULPI TX arbiter.
// The instruction layout matches the sync-mode TX machine:
// a 2-bit opcode in [7:6] and a 6-bit payload in [5:0].
package oup_ulpi_tx_arbiter_p;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERR       = 3'd4
    } arb_state_t;

    // Requesters that share the TX machine.
    typedef enum logic {
        REQ_REG = 1'b0,
        REQ_PKT = 1'b1
    } requester_t;

    // Immediate address value that selects an extended register access.
    localparam logic [5:0] ULPI_EXTREG_IMM = 6'h2F;

    // Instruction opcodes.
    localparam logic [1:0] OPC_TRANSMIT = 2'b01;
    localparam logic [1:0] OPC_REGW     = 2'b10;
    localparam logic [1:0] OPC_REGR     = 2'b11;

    // The instruction byte, viewed either raw or as opcode/payload.
    typedef union packed {
        logic [7:0] raw;
        struct packed {
            logic [1:0] opcode;
            logic [5:0] data;
        } f;
    } instruction_union_t;

    // Build the TX instruction for a granted request.
    // - Packets carry the PID in the low nibble.
    // - Register addresses that fit in 6 bits are sent immediately.
    // - 8'h2F would collide with the extended-access escape, so it is
    //   sent as an extended access, like every address above 8'h3F.
    function automatic instruction_union_t encode_instruction(
        input requester_t requester,
        input logic       we,
        input logic [7:0] addr,
        input logic [3:0] pid
    );
        instruction_union_t instr;
        instr.raw = 8'h00;
        if (requester == REQ_PKT) begin
            instr.f.opcode = OPC_TRANSMIT;
            instr.f.data   = {2'b00, pid};
        end else begin
            instr.f.opcode = we ? OPC_REGW : OPC_REGR;
            if ((addr <= 8'h3F) && (addr != {2'b00, ULPI_EXTREG_IMM})) begin
                instr.f.data = addr[5:0];
            end else begin
                instr.f.data = ULPI_EXTREG_IMM;
            end
        end
        return instr;
    endfunction

endpackage

// File: rtl/oup_ulpi_tx_arb2.sv
// Two-way request selector for the ULPI TX arbiter.
// - Default build: fixed priority, with the register port winning a tie.
// - With OUP_ULPI_TX_ARB_RR_EN defined: a tie goes to the requester not
//   served last. The remembered owner is updated when a transaction
//   completes; after reset it favours the register port.
module oup_ulpi_tx_arb2
    import oup_ulpi_tx_arbiter_p::*;
(
`ifdef OUP_ULPI_TX_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       served_valid,
    input  requester_t served_owner,
`endif
    input  logic       req_reg,
    input  logic       req_pkt,
    output logic       gnt_valid,
    output requester_t gnt_owner
);

`ifdef OUP_ULPI_TX_ARB_RR_EN
    requester_t last_r;

    // Remember the owner of the most recently completed transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= REQ_PKT;
        end else if (served_valid) begin
            last_r <= served_owner;
        end else begin
            last_r <= last_r;
        end
    end

    // Select a winner; on a tie, prefer whoever was not served last.
    always_comb begin
        gnt_valid = req_reg | req_pkt;
        gnt_owner = REQ_REG;
        if (req_reg && req_pkt) begin
            gnt_owner = (last_r == REQ_REG) ? REQ_PKT : REQ_REG;
        end else if (req_pkt) begin
            gnt_owner = REQ_PKT;
        end else begin
            gnt_owner = REQ_REG;
        end
    end
`else
    // Select a winner; the register port always wins a tie.
    always_comb begin
        gnt_valid = req_reg | req_pkt;
        gnt_owner = REQ_REG;
        if (req_reg) begin
            gnt_owner = REQ_REG;
        end else if (req_pkt) begin
            gnt_owner = REQ_PKT;
        end else begin
            gnt_owner = REQ_REG;
        end
    end
`endif

endmodule

// File: rtl/oup_ulpi_tx_arbiter.sv
// Sequencer and arbiter in front of the ULPI sync-mode TX machine.
// It grants one of two requesters (packet engine, PHY register port),
// encodes the instruction, drives exec, and re-issues after an abort up
// to MAX_RETRY times. It gives up with an error if the TX machine does
// not accept exec within START_TIMEOUT cycles.
// Optional macro: OUP_ULPI_TX_ARB_RR_EN selects round-robin tie-breaking.
module oup_ulpi_tx_arbiter
    import oup_ulpi_tx_arbiter_p::*;
#(
    parameter int MAX_RETRY     = 3,
    parameter int START_TIMEOUT = 64
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_ni,
    input  logic       pkt_req_i,
    input  logic [3:0] pkt_pid_i,
    output logic       pkt_gnt_o,
    output logic       pkt_done_o,
    output logic       pkt_err_o,
    input  logic       reg_req_i,
    input  logic       reg_we_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] reg_wdata_i,
    output logic       reg_gnt_o,
    output logic       reg_done_o,
    output logic       reg_err_o,
    output logic [7:0] instruction_o,
    output logic       exec_o,
    input  logic       exec_ready_i,
    input  logic       exec_aborted_i,
    output logic [7:0] phyreg_o,
    output logic [7:0] phyreg_addr_o,
    output logic       busy_o
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int START_W = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);

    arb_state_t          state_r;
    requester_t          owner_r;
    logic [RETRY_W-1:0]  retry_r;
    logic [START_W-1:0]  start_r;
    logic [7:0]          instruction_r;
    logic [7:0]          phyreg_r;
    logic [7:0]          phyreg_addr_r;
    logic                exec_r;
    logic                busy_r;
    logic                pkt_gnt_r, pkt_done_r, pkt_err_r;
    logic                reg_gnt_r, reg_done_r, reg_err_r;

    logic                arb_valid_s;
    requester_t          arb_owner_s;

    oup_ulpi_tx_arb2 u_arb2 (
`ifdef OUP_ULPI_TX_ARB_RR_EN
        .clk          (ulpi_clk_i),
        .rst_n        (rst_ni),
        .served_valid ((state_r == ST_DONE) || (state_r == ST_ERR)),
        .served_owner (owner_r),
`endif
        .req_reg      (reg_req_i),
        .req_pkt      (pkt_req_i),
        .gnt_valid    (arb_valid_s),
        .gnt_owner    (arb_owner_s)
    );

    // Main sequencer: grant, issue, wait for completion, retry, report.
    always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            owner_r       <= REQ_REG;
            retry_r       <= '0;
            start_r       <= '0;
            instruction_r <= 8'h00;
            phyreg_r      <= 8'h00;
            phyreg_addr_r <= 8'h00;
            exec_r        <= 1'b0;
            busy_r        <= 1'b0;
            pkt_gnt_r     <= 1'b0;
            pkt_done_r    <= 1'b0;
            pkt_err_r     <= 1'b0;
            reg_gnt_r     <= 1'b0;
            reg_done_r    <= 1'b0;
            reg_err_r     <= 1'b0;
        end else begin
            pkt_gnt_r  <= 1'b0;
            pkt_done_r <= 1'b0;
            pkt_err_r  <= 1'b0;
            reg_gnt_r  <= 1'b0;
            reg_done_r <= 1'b0;
            reg_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        owner_r       <= arb_owner_s;
                        instruction_r <= encode_instruction(arb_owner_s, reg_we_i,
                                                            reg_addr_i, pkt_pid_i);
                        if (arb_owner_s == REQ_REG) begin
                            reg_gnt_r     <= 1'b1;
                            phyreg_r      <= reg_wdata_i;
                            phyreg_addr_r <= reg_addr_i;
                        end else begin
                            pkt_gnt_r     <= 1'b1;
                            phyreg_r      <= 8'h00;
                            phyreg_addr_r <= 8'h00;
                        end
                        retry_r <= '0;
                        start_r <= '0;
                        exec_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!exec_ready_i) begin
                        exec_r  <= 1'b0;
                        state_r <= ST_WAIT_DONE;
                    end else if (start_r == START_LAST) begin
                        // TX machine never left IDLE (e.g. PHY holding dir).
                        exec_r    <= 1'b0;
                        reg_err_r <= (owner_r == REQ_REG);
                        pkt_err_r <= (owner_r == REQ_PKT);
                        state_r   <= ST_ERR;
                    end else begin
                        start_r <= start_r + START_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (exec_ready_i) begin
                        if (!exec_aborted_i) begin
                            reg_done_r <= (owner_r == REQ_REG);
                            pkt_done_r <= (owner_r == REQ_PKT);
                            state_r    <= ST_DONE;
                        end else if (retry_r < RETRY_MAX) begin
                            // Re-issue the same instruction.
                            retry_r <= retry_r + RETRY_W'(1);
                            start_r <= '0;
                            exec_r  <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else begin
                            reg_err_r <= (owner_r == REQ_REG);
                            pkt_err_r <= (owner_r == REQ_PKT);
                            state_r   <= ST_ERR;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    retry_r <= '0;
                    start_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    exec_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    retry_r <= '0;
                    start_r <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkt_gnt_o     = pkt_gnt_r;
    assign pkt_done_o    = pkt_done_r;
    assign pkt_err_o     = pkt_err_r;
    assign reg_gnt_o     = reg_gnt_r;
    assign reg_done_o    = reg_done_r;
    assign reg_err_o     = reg_err_r;
    assign instruction_o = instruction_r;
    assign exec_o        = exec_r;
    assign phyreg_o      = phyreg_r;
    assign phyreg_addr_o = phyreg_addr_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_oup_ulpi_tx_arbiter.sv
// Self-checking bench for oup_ulpi_tx_arbiter with a behavioural TX machine.
// The TX model accepts exec when ready and stays busy for a few cycles.
// It aborts the first abort_plan issues of a transaction, and ignores exec
// entirely while stall is set.
module tb_oup_ulpi_tx_arbiter;

    logic       ulpi_clk = 1'b0;
    logic       rst_n;
    logic       pkt_req = 1'b0;
    logic [3:0] pkt_pid = 4'h0;
    logic       pkt_gnt, pkt_done, pkt_err;
    logic       reg_req = 1'b0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] reg_wdata = 8'h00;
    logic       reg_gnt, reg_done, reg_err;
    logic [7:0] instruction;
    logic       exec;
    logic       m_ready;
    logic       m_abort;
    logic [7:0] phyreg;
    logic [7:0] phyreg_addr;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   issue_cnt = 0;
    int   issue_base = 0;
    int   abort_plan = 0;
    logic stall = 1'b0;
    int   m_busy;

    always #5 ulpi_clk = ~ulpi_clk;

    oup_ulpi_tx_arbiter dut (
        .ulpi_clk_i     (ulpi_clk),
        .rst_ni         (rst_n),
        .pkt_req_i      (pkt_req),
        .pkt_pid_i      (pkt_pid),
        .pkt_gnt_o      (pkt_gnt),
        .pkt_done_o     (pkt_done),
        .pkt_err_o      (pkt_err),
        .reg_req_i      (reg_req),
        .reg_we_i       (reg_we),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_gnt_o      (reg_gnt),
        .reg_done_o     (reg_done),
        .reg_err_o      (reg_err),
        .instruction_o  (instruction),
        .exec_o         (exec),
        .exec_ready_i   (m_ready),
        .exec_aborted_i (m_abort),
        .phyreg_o       (phyreg),
        .phyreg_addr_o  (phyreg_addr),
        .busy_o         (busy)
    );

    // Behavioural TX machine.
    always @(posedge ulpi_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_abort <= 1'b0;
            m_busy  <= 0;
        end else if (stall) begin
            m_ready <= 1'b1;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) m_ready <= 1'b1;
        end else if (exec && m_ready) begin
            m_ready   <= 1'b0;
            m_busy    <= 3;
            m_abort   <= ((issue_cnt - issue_base) < abort_plan);
            issue_cnt <= issue_cnt + 1;
        end
    end

    typedef struct {
        logic       is_reg;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [3:0] pid;
        int         aborts;
        logic       stall;
        logic [7:0] exp_instr;
        logic       exp_err;
        int         exp_issues;
    } vec_t;

    typedef struct {
        logic       is_reg;
        logic [7:0] instr;
        logic [7:0] paddr;
        logic [7:0] preg;
        logic       err;
        int         issues;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    function automatic exp_t mk(input logic is_reg, input logic [7:0] instr,
                                input logic [7:0] paddr, input logic [7:0] preg,
                                input logic err, input int issues);
        exp_t e;
        e.is_reg = is_reg;
        e.instr  = instr;
        e.paddr  = paddr;
        e.preg   = preg;
        e.err    = err;
        e.issues = issues;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected response", name);
    endtask

    // Run the bus until n_exp responses arrive, checking against the scoreboard.
    task automatic service(input int max_cyc, input int n_exp, input bit drop_all,
                           output int gnt_cyc, output int end_cyc);
        int   n_done = 0;
        bit   idle_chk = 1'b0;
        bit   exec_chk = 1'b0;
        exp_t e;
        logic [3:0] exp_pulses;
        gnt_cyc = -1;
        end_cyc = -1;
        for (int c = 1; c <= max_cyc && n_done < n_exp; c++) begin
            @(negedge ulpi_clk);
            if (idle_chk) begin
                check("idle_after_resp", {31'd0, busy}, 32'd0);
                idle_chk = 1'b0;
            end
            if (exec_chk) begin
                check("exec_drop", {31'd0, exec}, 32'd0);
                exec_chk = 1'b0;
            end
            if (exec && !m_ready) exec_chk = 1'b1;
            if (reg_gnt || pkt_gnt) begin
                if (gnt_cyc < 0) gnt_cyc = c;
                if (sb_q.size() == 0) begin
                    fail_now("gnt_unexpected");
                end else begin
                    check("gnt_owner", {30'd0, reg_gnt, pkt_gnt},
                          sb_q[0].is_reg ? 32'd2 : 32'd1);
                    check("instr_at_gnt", {24'd0, instruction}, {24'd0, sb_q[0].instr});
                    check("exec_at_gnt", {31'd0, exec}, 32'd1);
                end
                if (reg_gnt || drop_all) reg_req = 1'b0;
                if (pkt_gnt || drop_all) pkt_req = 1'b0;
            end
            if (reg_done || reg_err || pkt_done || pkt_err) begin
                if (end_cyc < 0) end_cyc = c;
                if (sb_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    e = sb_q.pop_front();
                    exp_pulses = e.is_reg ? (e.err ? 4'b0100 : 4'b1000)
                                          : (e.err ? 4'b0001 : 4'b0010);
                    check("resp_pulses", {28'd0, reg_done, reg_err, pkt_done, pkt_err},
                          {28'd0, exp_pulses});
                    check("instr_at_resp", {24'd0, instruction}, {24'd0, e.instr});
                    check("exec_low_at_resp", {31'd0, exec}, 32'd0);
                    check("issue_count", issue_cnt - issue_base, e.issues);
                    if (e.is_reg) begin
                        check("phyreg_addr", {24'd0, phyreg_addr}, {24'd0, e.paddr});
                        check("phyreg", {24'd0, phyreg}, {24'd0, e.preg});
                    end
                end
                n_done++;
                idle_chk = 1'b1;
            end
        end
        if (n_done < n_exp) fail_now("resp_wait");
        if (idle_chk) begin
            @(negedge ulpi_clk);
            check("idle_after_resp", {31'd0, busy}, 32'd0);
            check("pulse_width", {28'd0, reg_done, reg_err, pkt_done, pkt_err}, 32'd0);
        end
    endtask

    initial begin
        int   g;
        int   e;
        bit   reached;
        logic exp_reg;

        //           is_reg we    addr   wdata  pid  ab stall instr  err iss
        vecs[0] = '{1'b1, 1'b1, 8'h16, 8'hA5, 4'h0, 0, 1'b0, 8'h96, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 8'h85, 8'h00, 4'h0, 0, 1'b0, 8'hEF, 1'b0, 1};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 4'h1, 2, 1'b0, 8'h41, 1'b0, 3};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 4'h1, 4, 1'b0, 8'h41, 1'b1, 4};
        vecs[4] = '{1'b1, 1'b1, 8'h2F, 8'h3C, 4'h0, 0, 1'b0, 8'hAF, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 8'h3F, 8'h11, 4'h0, 0, 1'b0, 8'hFF, 1'b0, 1};
        vecs[6] = '{1'b1, 1'b1, 8'h40, 8'h5A, 4'h0, 0, 1'b0, 8'hAF, 1'b0, 1};
        vecs[7] = '{1'b1, 1'b0, 8'h01, 8'h00, 4'h0, 0, 1'b1, 8'hC1, 1'b1, 0};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 4'hD, 3, 1'b0, 8'h4D, 1'b0, 4};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge ulpi_clk);
        check("reset_outputs",
              {pkt_gnt, pkt_done, pkt_err, reg_gnt, reg_done, reg_err, exec, busy,
               instruction, phyreg, phyreg_addr}, 32'd0);
        rst_n = 1'b1;
        @(negedge ulpi_clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // Single-requester transactions from the table.
        for (int i = 0; i < 9; i++) begin
            @(negedge ulpi_clk);
            stall      = vecs[i].stall;
            abort_plan = vecs[i].aborts;
            issue_base = issue_cnt;
            reg_we     = vecs[i].we;
            reg_addr   = vecs[i].addr;
            reg_wdata  = vecs[i].wdata;
            pkt_pid    = vecs[i].pid;
            sb_q.push_back(mk(vecs[i].is_reg, vecs[i].exp_instr, vecs[i].addr,
                              vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_issues));
            if (vecs[i].is_reg) reg_req = 1'b1;
            else                pkt_req = 1'b1;
            service(200, 1, 1'b0, g, e);
            check("gnt_latency", g, 32'd1);
            if (vecs[i].stall) check("timeout_cycles", e - g, 32'd64);
        end
        stall = 1'b0;

        // Reset while waiting for the TX machine; a pending request follows.
        @(negedge ulpi_clk);
        abort_plan = 0;
        issue_base = issue_cnt;
        reg_we = 1'b1; reg_addr = 8'h10; reg_wdata = 8'h77;
        reg_req = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge ulpi_clk);
            if (reg_gnt) reg_req = 1'b0;
            if (busy && !exec) reached = 1'b1;
        end
        if (!reached) fail_now("reach_wait_done");
        pkt_pid = 4'h2;
        pkt_req = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("reset_mid_op",
              {pkt_gnt, pkt_done, pkt_err, reg_gnt, reg_done, reg_err, exec, busy,
               instruction, phyreg, phyreg_addr}, 32'd0);
        @(negedge ulpi_clk);
        rst_n = 1'b1;
        issue_base = issue_cnt;
        sb_q.push_back(mk(1'b0, 8'h42, 8'h00, 8'h00, 1'b0, 1));
        service(50, 1, 1'b0, g, e);
        check("gnt_latency_after_reset", g, 32'd1);

        // Simultaneous requests, three rounds, loser withdraws after the grant.
        reg_we = 1'b1; reg_addr = 8'h05; pkt_pid = 4'h3;
        for (int r = 0; r < 3; r++) begin
            @(negedge ulpi_clk);
`ifdef OUP_ULPI_TX_ARB_RR_EN
            exp_reg = (r != 1);
`else
            exp_reg = 1'b1;
`endif
            reg_wdata  = 8'(r);
            issue_base = issue_cnt;
            sb_q.push_back(exp_reg ? mk(1'b1, 8'h85, 8'h05, 8'(r), 1'b0, 1)
                                   : mk(1'b0, 8'h43, 8'h00, 8'h00, 1'b0, 1));
            reg_req = 1'b1;
            pkt_req = 1'b1;
            service(60, 1, 1'b1, g, e);
            check("tie_gnt_latency", g, 32'd1);
        end

        // Both requesters hold until served: both are granted in turn.
        @(negedge ulpi_clk);
        reg_we = 1'b0; reg_addr = 8'h2A; reg_wdata = 8'h99; pkt_pid = 4'hC;
        issue_base = issue_cnt;
`ifdef OUP_ULPI_TX_ARB_RR_EN
        sb_q.push_back(mk(1'b0, 8'h4C, 8'h00, 8'h00, 1'b0, 1));
        sb_q.push_back(mk(1'b1, 8'hEA, 8'h2A, 8'h99, 1'b0, 2));
`else
        sb_q.push_back(mk(1'b1, 8'hEA, 8'h2A, 8'h99, 1'b0, 1));
        sb_q.push_back(mk(1'b0, 8'h4C, 8'h00, 8'h00, 1'b0, 2));
`endif
        reg_req = 1'b1;
        pkt_req = 1'b1;
        service(100, 2, 1'b0, g, e);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
